// File: rtl/blockchain_ram_arbiter_pkg.sv
// Shared constants and types for the blockchain RAM arbiter.
package blockchain_ram_arbiter_pkg;

   // Requester indices; OWNER_NONE marks an idle bus.
   localparam logic [1:0] PORT_STORE   = 2'd0;
   localparam logic [1:0] PORT_MINER   = 2'd1;
   localparam logic [1:0] PORT_DISPLAY = 2'd2;
   localparam logic [1:0] OWNER_NONE   = 2'd3;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StOwn  = 1'b1
   } arb_state_e;

   // One-hot grant vector for a port index; OWNER_NONE maps to all zeros.
   function automatic logic [2:0] port_onehot(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         PORT_STORE:   oh = 3'b001;
         PORT_MINER:   oh = 3'b010;
         PORT_DISPLAY: oh = 3'b100;
         default:      oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/blockchain_ram_arbiter_rr_picker.sv
// Round-robin choice between the miner and display ports.
module blockchain_ram_arbiter_rr_picker
   import blockchain_ram_arbiter_pkg::*;
(
   input  logic [1:0] req_hi,      // bit0 = miner, bit1 = display
   input  logic [1:0] last_owner,
   output logic [1:0] winner,
   output logic       found
);

   // Start the search just after the port that last held the bus.
   always_comb begin
      winner = OWNER_NONE;
      found  = 1'b0;
      if (last_owner == PORT_MINER) begin
         if (req_hi[1]) begin
            winner = PORT_DISPLAY;
            found  = 1'b1;
         end else if (req_hi[0]) begin
            winner = PORT_MINER;
            found  = 1'b1;
         end
      end else begin
         if (req_hi[0]) begin
            winner = PORT_MINER;
            found  = 1'b1;
         end else if (req_hi[1]) begin
            winner = PORT_DISPLAY;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/blockchain_ram_arbiter.sv
// Three-way arbiter for the single-port blockchain RAM: store has priority,
// miner and display share by round-robin with a bounded hold time.
module blockchain_ram_arbiter
   import blockchain_ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [2:0]            req,
   input  logic [2:0]            wr,
   input  logic [3*ADDR_W-1:0]   addr,
   input  logic [3*DATA_W-1:0]   wdata,
   output logic [2:0]            gnt,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   output logic                  ram_wren,
   input  logic [DATA_W-1:0]     ram_q,
   output logic [DATA_W-1:0]     rdata,
   output logic [2:0]            rvalid,
   output logic [1:0]            owner
);

   localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

   arb_state_e       state_q;
   logic [1:0]       owner_q;
   logic [1:0]       last_owner_q;
   logic [HoldW-1:0] hold_q;
   logic [2:0]       gnt_q;
   logic [2:0]       rvalid_q;

   logic             own_req;
   logic             own_wr;
   logic             others_pending;
   logic             preempt;
   logic [1:0]       rr_winner;
   logic             rr_found;
   logic [1:0]       win;
   logic             win_found;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   blockchain_ram_arbiter_rr_picker u_rr_picker (
      .req_hi     (req[2:1]),
      .last_owner (last_owner_q),
      .winner     (rr_winner),
      .found      (rr_found)
   );

   // Owner's request state; gnt_q is the one-hot form of owner_q.
   always_comb begin
      own_req        = |(req & gnt_q);
      own_wr         = |(wr & gnt_q);
      others_pending = |(req & ~gnt_q);
      // Store is never cut short, even under contention.
      preempt        = (hold_q == HoldLast) && others_pending && (owner_q != PORT_STORE);
      win            = req[0] ? PORT_STORE : rr_winner;
      win_found      = req[0] | rr_found;
   end

   // Route the owning port's address and write data to the RAM.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      case (owner_q)
         PORT_STORE: begin
            sel_addr  = addr[0 +: ADDR_W];
            sel_wdata = wdata[0 +: DATA_W];
         end
         PORT_MINER: begin
            sel_addr  = addr[ADDR_W +: ADDR_W];
            sel_wdata = wdata[DATA_W +: DATA_W];
         end
         PORT_DISPLAY: begin
            sel_addr  = addr[2*ADDR_W +: ADDR_W];
            sel_wdata = wdata[2*DATA_W +: DATA_W];
         end
         default: begin
            sel_addr  = '0;
            sel_wdata = '0;
         end
      endcase
   end

   // RAM drive; forced quiet while reset is held so an in-flight write is dropped.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wren  = 1'b0;
      if (!reset && (state_q == StOwn)) begin
         ram_addr  = sel_addr;
         ram_wdata = sel_wdata;
         ram_wren  = own_req & own_wr;
      end
   end

   // Arbitration FSM with registered grant, owner and read strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         owner_q      <= OWNER_NONE;
         last_owner_q <= PORT_DISPLAY;
         hold_q       <= '0;
         gnt_q        <= 3'b000;
         rvalid_q     <= 3'b000;
      end else begin
         rvalid_q <= 3'b000;
         unique case (state_q)
            StIdle: begin
               if (win_found) begin
                  state_q <= StOwn;
                  owner_q <= win;
                  gnt_q   <= port_onehot(win);
                  hold_q  <= '0;
               end
            end
            StOwn: begin
               // RAM data arrives one cycle after the read address.
               if (own_req && !own_wr) begin
                  rvalid_q <= gnt_q;
               end
               // Saturate so an uncontended long hold releases as soon as someone waits.
               if (hold_q != HoldLast) begin
                  hold_q <= hold_q + 1'b1;
               end
               if (!own_req || preempt) begin
                  state_q      <= StIdle;
                  gnt_q        <= 3'b000;
                  last_owner_q <= owner_q;
                  owner_q      <= OWNER_NONE;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign gnt    = gnt_q;
   assign rvalid = rvalid_q;
   assign owner  = owner_q;
   assign rdata  = ram_q;

endmodule

// File: tb/tb_blockchain_ram_arbiter.sv
// Self-checking bench for blockchain_ram_arbiter with a behavioural RAM and
// a read-data scoreboard.
module tb_blockchain_ram_arbiter;
   import blockchain_ram_arbiter_pkg::*;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned MAX_HOLD = 8;

   logic                clock = 1'b0;
   logic                reset;
   logic [2:0]          req;
   logic [2:0]          wr;
   logic [3*ADDR_W-1:0] addr;
   logic [3*DATA_W-1:0] wdata;
   logic [2:0]          gnt;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;
   logic                ram_wren;
   logic [DATA_W-1:0]   ram_q;
   logic [DATA_W-1:0]   rdata;
   logic [2:0]          rvalid;
   logic [1:0]          owner;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [2:0]        vld;
      logic [DATA_W-1:0] data;
   } rd_exp_t;

   rd_exp_t           sb_q[$];
   logic [DATA_W-1:0] mem     [32];
   logic [DATA_W-1:0] exp_mem [32];

   blockchain_ram_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .wr        (wr),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_wren  (ram_wren),
      .ram_q     (ram_q),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .owner     (owner)
   );

   always #10 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Single-port RAM with one-cycle read latency.
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = {32'hC0DE_0000, 32'(i)};
      forever begin
         @(posedge clock);
         if (ram_wren) mem[ram_addr] <= ram_wdata;
         ram_q <= mem[ram_addr];
      end
   end

   // Every read strobe must match the oldest outstanding expected read.
   always @(negedge clock) begin
      rd_exp_t e;
      if (rvalid != 3'b000) begin
         if (sb_q.size() == 0) begin
            check_eq("rv_spurious", 64'(rvalid), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq("rvalid", 64'(rvalid), 64'(e.vld));
            check_eq("rdata", rdata, e.data);
         end
      end
   end

   // One cycle: check grant/owner/RAM drive against the expected grant at the
   // negedge, queue expected read data, then return just after the posedge.
   task automatic step(input logic [2:0] exp_gnt);
      int                p;
      logic [1:0]        exp_owner;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      rd_exp_t           e;
      @(negedge clock);
      case (exp_gnt)
         3'b001:  p = 0;
         3'b010:  p = 1;
         3'b100:  p = 2;
         default: p = -1;
      endcase
      exp_owner = (p >= 0) ? 2'(p) : 2'd3;
      check_eq("gnt", 64'(gnt), 64'(exp_gnt));
      check_eq("owner", 64'(owner), 64'(exp_owner));
      if (p >= 0 && req[p]) begin
         a = addr[p*ADDR_W +: ADDR_W];
         d = wdata[p*DATA_W +: DATA_W];
         check_eq("ram_addr", 64'(ram_addr), 64'(a));
         if (wr[p]) begin
            check_eq("ram_wren", 64'(ram_wren), 64'd1);
            check_eq("ram_wdata", ram_wdata, d);
            exp_mem[a] = d;
         end else begin
            check_eq("ram_wren", 64'(ram_wren), 64'd0);
            e.vld  = 3'b001 << p;
            e.data = exp_mem[a];
            sb_q.push_back(e);
         end
      end else begin
         check_eq("ram_wren", 64'(ram_wren), 64'd0);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] ex;
      for (int i = 0; i < 32; i++) exp_mem[i] = {32'hC0DE_0000, 32'(i)};
      reset = 1'b1;
      req   = 3'b000;
      wr    = 3'b000;
      addr  = '0;
      wdata = '0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_gnt", 64'(gnt), 64'd0);
      check_eq("rst_rvalid", 64'(rvalid), 64'd0);
      check_eq("rst_owner", 64'(owner), 64'd3);
      check_eq("rst_wren", 64'(ram_wren), 64'd0);
      check_eq("rst_addr", 64'(ram_addr), 64'd0);
      check_eq("rst_wdata", ram_wdata, 64'd0);
      reset = 1'b0;

      // Lone miner read of address 5
      req = 3'b010;
      addr[ADDR_W +: ADDR_W] = 5'd5;
      step(3'b000);
      repeat (3) step(3'b010);
      req = 3'b000;
      step(3'b010);
      step(3'b000);
      step(3'b000);
      check_eq("lone_sb_empty", 64'(sb_q.size()), 64'd0);

      // All three request: store writes first, then miner, then preemption to display
      wdata[0 +: DATA_W]       = 64'hDEAD_BEEF;
      addr[0 +: ADDR_W]        = 5'd3;
      addr[ADDR_W +: ADDR_W]   = 5'd3;
      addr[2*ADDR_W +: ADDR_W] = 5'd9;
      wr  = 3'b001;
      req = 3'b111;
      step(3'b000);
      step(3'b001);
      step(3'b001);
      req[0] = 1'b0;
      step(3'b001);
      step(3'b000);
      repeat (MAX_HOLD) step(3'b010);
      step(3'b000);
      step(3'b100);
      step(3'b100);
      req = 3'b000;
      step(3'b100);
      step(3'b000);
      step(3'b000);
      check_eq("preempt_sb_empty", 64'(sb_q.size()), 64'd0);

      // Round-robin with 2-cycle bursts from miner and display
      wr  = 3'b000;
      addr[ADDR_W +: ADDR_W]   = 5'd7;
      addr[2*ADDR_W +: ADDR_W] = 5'd9;
      req = 3'b110;
      step(3'b000);
      for (int g = 0; g < 4; g++) begin
         int p;
         p  = (g % 2 == 0) ? 1 : 2;
         ex = 3'b001 << p;
         step(ex);
         step(ex);
         req[p] = 1'b0;
         step(ex);
         if (g < 3) req[p] = 1'b1;
         else req = 3'b000;
         step(3'b000);
      end
      step(3'b000);
      check_eq("rr_sb_empty", 64'(sb_q.size()), 64'd0);

      // Store holds 20 cycles while display waits
      addr[0 +: ADDR_W] = 5'd3;
      req = 3'b101;
      step(3'b000);
      repeat (20) step(3'b001);
      req[0] = 1'b0;
      step(3'b001);
      step(3'b000);
      step(3'b100);
      req = 3'b000;
      step(3'b100);
      step(3'b000);
      step(3'b000);
      check_eq("store_sb_empty", 64'(sb_q.size()), 64'd0);

      // Reset in the middle of a store write burst
      addr[0 +: ADDR_W]  = 5'd12;
      wdata[0 +: DATA_W] = 64'h1234_5678_9ABC_DEF0;
      wr  = 3'b001;
      req = 3'b001;
      step(3'b000);
      step(3'b001);
      reset = 1'b1;
      #1;
      check_eq("midrst_wren", 64'(ram_wren), 64'd0);
      check_eq("midrst_gnt", 64'(gnt), 64'd0);
      check_eq("midrst_owner", 64'(owner), 64'd3);
      check_eq("midrst_rvalid", 64'(rvalid), 64'd0);
      check_eq("midrst_addr", 64'(ram_addr), 64'd0);
      check_eq("midrst_wdata", ram_wdata, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      req   = 3'b000;
      wr    = 3'b000;

      // After reset last_owner is display, so miner wins; read back the stored word
      addr[ADDR_W +: ADDR_W]   = 5'd12;
      addr[2*ADDR_W +: ADDR_W] = 5'd9;
      req = 3'b110;
      step(3'b000);
      step(3'b010);
      req = 3'b000;
      step(3'b010);
      step(3'b000);
      step(3'b000);
      check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
